data_tx_mc: RTL
===============

DATA_TX_MC -- requirements
Module: data_tx_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/register width; legal values 32 or 64.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two; AW = log2(NREGS).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports instr_valid input 1 and instr_ready output 1  instruction handshake.
REQ-006 SHALL have ports opcode input 7, funct3 input 3, funct7 input 7  instruction decode fields.
REQ-007 SHALL have ports RS1, RS2, RD input AW each  register indices; Imm_reg input 12  immediate.
REQ-008 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output WIDTH, mem_wdata output WIDTH, mem_be output WIDTH/8  memory request.
REQ-009 SHALL have ports mem_ack input 1, mem_rdata input WIDTH  memory response.
REQ-010 SHALL have ports done output 1 (retire pulse), busy output 1, ALU_data_out, RS1_data_out, RS2_data_out output WIDTH each (debug).

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> (MEM) -> WB -> IDLE; instr_ready=1 only in IDLE; busy=1 in all states except IDLE.
REQ-012 SHALL capture all instruction fields on the edge where instr_valid && instr_ready.
REQ-013 SHALL in EXEC read RS1/RS2, compute result or byte address RS1+sext(Imm_reg), register it.
REQ-014 SHALL decode opcode 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE); any other opcode retires as NOP via EXEC->WB with no write.
REQ-015 SHALL support ADD, SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]), OR, AND; shift amount = low log2(WIDTH) bits of operand B; arithmetic modulo 2^WIDTH.
REQ-016 SHALL for LOAD/STORE go EXEC->MEM, hold mem_req=1 and all mem_* stable until mem_ack=1, then go to WB on the next edge.
REQ-017 SHALL support sizes per funct3[1:0]: byte, half, word, and double (011) only when WIDTH=64; mem_be selects lanes from mem_addr low bits; store data shifted into selected lanes.
REQ-018 SHALL sign-extend loads for funct3[2]=0, zero-extend for funct3[2]=1.
REQ-019 SHALL in WB write result to RD at end of cycle and assert done for exactly one cycle; stores and NOPs write nothing.
REQ-020 SHALL hardwire register 0 to zero; writes to RD=0 discarded.
REQ-021 SHALL give latency: ALU/NOP accept edge +3 cycles to done; load/store 4 cycles + mem_ack wait cycles.
REQ-022 SHALL make an RD write visible to the very next accepted instruction (no hazard).
REQ-023 SHALL ignore mem_ack outside MEM.

Reset
REQ-024 SHALL on rst=0 immediately force IDLE, mem_req=0, mem_we=0, done=0, busy=0, all data outputs 0, all registers 0, including mid-MEM; an in-flight instruction is dropped.
REQ-025 SHALL be instr_ready=1 the first cycle after rst deasserts.

Configuration
REQ-026 SHALL with DP_ALIGN_CHECK_EN defined: misaligned half/word/double access skips MEM, goes to WB, writes nothing, output err (1 bit) pulses with done.
REQ-027 SHALL without DP_ALIGN_CHECK_EN: no err port; misaligned address has low bits cleared to access size before issue.

Structure
REQ-028 SHALL place opcode constants, funct3 size codes, ALU-op enum and FSM-state enum in package dp_pkg.
REQ-029 SHALL instantiate sub-module dp_regfile (NREGS x WIDTH, 2 read, 1 write, x0 zero, async reset).

Verification
REQ-030 SHALL test ADD: x1=5, x2=7, ADD x3,x1,x2 -> done 3 cycles after accept, x3=12.
REQ-031 SHALL test SUB/SRA: x1=0x00000003, SUB x4,x0,x1 -> 0xFFFFFFFD; SRA x5,x4,(x2=1) -> 0xFFFFFFFE.
REQ-032 SHALL test store/load: SB x4 to addr 0x103 -> mem_be=1000, mem_wdata[31:24]=0xFD; LB returning 0xFD000000 -> 0xFFFFFFFD; LBU -> 0x000000FD.
REQ-033 SHALL test mem_ack delayed 5 cycles -> mem_req held 5 cycles, fields stable, done 1 cycle after ack cycle.
REQ-034 SHALL test rst low during MEM -> mem_req=0 same cycle, x1..x31=0, instr_ready=1 after release.
REQ-035 SHALL test LW at addr 0x102 -> with DP_ALIGN_CHECK_EN err=1 with done, no mem_req; without, mem_addr=0x100, mem_be=1111.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared decode constants, ALU operation and FSM state types for data_tx_mc.
package dp_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MEM, ST_WB} state_e;

  // SUB only exists in R-type; SRA/SRL split on funct7[5] for both forms
  function automatic alu_op_e alu_decode(input logic is_r, input logic [2:0] f3,
                                         input logic f7b5);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: NREGS x WIDTH, two async read ports, one write port, x0 reads zero.
module dp_regfile #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] regs [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/data_tx_mc.sv
// Multi-cycle integer core slice: IDLE -> EXEC -> (MEM) -> WB with a simple memory handshake.
// Optional DP_ALIGN_CHECK_EN: misaligned accesses retire with err instead of being aligned down.
module data_tx_mc
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [AW-1:0]      RS1,
  input  logic [AW-1:0]      RS2,
  input  logic [AW-1:0]      RD,
  input  logic [11:0]        Imm_reg,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_be,
  input  logic               mem_ack,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               done,
  output logic               busy,
`ifdef DP_ALIGN_CHECK_EN
  output logic               err,
`endif
  output logic [WIDTH-1:0]   ALU_data_out,
  output logic [WIDTH-1:0]   RS1_data_out,
  output logic [WIDTH-1:0]   RS2_data_out
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [6:0]        op_q, f7_q;
  logic [2:0]        f3_q;
  logic [AW-1:0]     rs1_q, rs2_q, rd_q;
  logic [11:0]       imm_q;
  logic              wr_q, rf_we;
  logic [WIDTH-1:0]  rs1_val, rs2_val, imm_sx, opb, alu_res;
  logic [WIDTH-1:0]  addr_raw, addr_issue, st_data, ld_sh, ld_al, ld_val;
  logic [1:0]        sz;
  logic [NB-1:0]     lanes, be;
  logic [OW-1:0]     off_mask;
  logic [SW-1:0]     shamt, ext_sh;
  logic              is_r, is_i, is_ld, is_st, is_mem, skip;
  alu_op_e           alu_op;
`ifdef DP_ALIGN_CHECK_EN
  logic              err_q;
`endif

  assign rf_we = (state_q == ST_WB) && wr_q;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst_n (rst),
    .ra1   (rs1_q),
    .ra2   (rs2_q),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (rf_we),
    .wa    (rd_q),
    .wd    (ALU_data_out)
  );

  // Decode and execute datapath on the captured instruction
  always_comb begin
    is_r     = (op_q == OP_R) && ((f7_q & 7'b1011111) == 7'd0);
    is_i     = (op_q == OP_I);
    is_ld    = (op_q == OP_LOAD);
    is_st    = (op_q == OP_STORE);
    is_mem   = is_ld || is_st;
    imm_sx   = WIDTH'($signed(imm_q));
    opb      = is_r ? rs2_val : imm_sx;
    shamt    = opb[SW-1:0];
    alu_op   = alu_decode(is_r, f3_q, f7_q[5]);
    addr_raw = rs1_val + imm_sx;
    case (alu_op)
      ALU_SUB:  alu_res = rs1_val - opb;
      ALU_SLL:  alu_res = rs1_val << shamt;
      ALU_SLT:  alu_res = WIDTH'($signed(rs1_val) < $signed(opb));
      ALU_SLTU: alu_res = WIDTH'(rs1_val < opb);
      ALU_XOR:  alu_res = rs1_val ^ opb;
      ALU_SRL:  alu_res = rs1_val >> shamt;
      ALU_SRA:  alu_res = WIDTH'($signed(rs1_val) >>> shamt);
      ALU_OR:   alu_res = rs1_val | opb;
      ALU_AND:  alu_res = rs1_val & opb;
      default:  alu_res = rs1_val + opb;
    endcase
  end

  // Access size, lane mask and load extension shift; double only exists at WIDTH=64
  always_comb begin
    sz = ((WIDTH == 64) || (f3_q[1:0] != SZ_D)) ? f3_q[1:0] : SZ_W;
    case (sz)
      SZ_B:    begin lanes = NB'(1);     off_mask = '0;     ext_sh = SW'(WIDTH - 8);  end
      SZ_H:    begin lanes = NB'(3);     off_mask = OW'(1); ext_sh = SW'(WIDTH - 16); end
      SZ_W:    begin lanes = NB'(4'hF);  off_mask = OW'(3); ext_sh = SW'(WIDTH - 32); end
      default: begin lanes = NB'(8'hFF); off_mask = OW'(7); ext_sh = '0;            end
    endcase
`ifdef DP_ALIGN_CHECK_EN
    skip       = is_mem && ((addr_raw[OW-1:0] & off_mask) != '0);
    addr_issue = addr_raw;
`else
    skip       = 1'b0;
    addr_issue = addr_raw & ~WIDTH'(off_mask);
`endif
    be      = lanes << addr_issue[OW-1:0];
    st_data = rs2_val << {addr_issue[OW-1:0], 3'b000};
    ld_sh   = mem_rdata >> {mem_addr[OW-1:0], 3'b000};
    ld_al   = ld_sh << ext_sh;
    ld_val  = f3_q[2] ? (ld_al >> ext_sh) : WIDTH'($signed(ld_al) >>> ext_sh);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (instr_valid && instr_ready) state_d = ST_EXEC;
      ST_EXEC: state_d = (is_mem && !skip) ? ST_MEM : ST_WB;
      ST_MEM:  if (mem_ack) state_d = ST_WB;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Registered outputs, captured fields and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      ALU_data_out <= '0;
      RS1_data_out <= '0;
      RS2_data_out <= '0;
      op_q         <= '0;
      f3_q         <= '0;
      f7_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      wr_q         <= 1'b0;
`ifdef DP_ALIGN_CHECK_EN
      err          <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      instr_ready <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      mem_req     <= (state_d == ST_MEM);
      done        <= (state_q == ST_WB);
`ifdef DP_ALIGN_CHECK_EN
      err         <= (state_q == ST_WB) && err_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q  <= opcode;
            f3_q  <= funct3;
            f7_q  <= funct7;
            rs1_q <= RS1;
            rs2_q <= RS2;
            rd_q  <= RD;
            imm_q <= Imm_reg;
          end
        end
        ST_EXEC: begin
          RS1_data_out <= rs1_val;
          RS2_data_out <= rs2_val;
          ALU_data_out <= is_mem ? addr_issue : alu_res;
          wr_q         <= (is_r || is_i || is_ld) && !skip;
`ifdef DP_ALIGN_CHECK_EN
          err_q        <= skip;
`endif
          if (is_mem && !skip) begin
            mem_we    <= is_st;
            mem_addr  <= addr_issue;
            mem_be    <= be;
            mem_wdata <= is_st ? st_data : '0;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (is_ld) ALU_data_out <= ld_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
